// File: rtl/serial_alu_if.sv
// serial_alu_if: handshake and data bundle between the control unit (master)
// and the bit-serial ALU (slave).
//   start, opcode, operand_a, operand_b : request side, driven by the master
//   alu_result, acc_write_en            : serial result stream towards the accumulator
//   busy, done, carry_flag, zero_flag   : status back to the control unit
interface serial_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             alu_result;
  logic             acc_write_en;
  logic             busy;
  logic             done;
  logic             carry_flag;
  logic             zero_flag;

  modport master (
    output start, opcode, operand_a, operand_b,
    input  alu_result, acc_write_en, busy, done, carry_flag, zero_flag
  );

  modport slave (
    input  start, opcode, operand_a, operand_b,
    output alu_result, acc_write_en, busy, done, carry_flag, zero_flag
  );
endinterface

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU stage feeding the accumulator.
// On start (sampled in IDLE) it latches both operands and the opcode, then
// streams the WIDTH-bit result LSB-first, one bit per clock, with
// acc_write_en high on every valid bit. A one-cycle done pulse follows the
// last bit, and the carry/zero flags are updated on that same edge.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_alu_if.slave (start/opcode/operands in; result stream,
//           busy, done and flags out)
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_alu_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSB = 3'b101,
    OP_INC   = 3'b110,
    OP_NOTA  = 3'b111
  } op_e;

  state_e           state;
  op_e              op;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic             zero_acc;
  logic             carry_flag_q;
  logic             zero_flag_q;

  logic             res_bit;
  logic             carry_nxt;
  logic             is_arith;

  // Per-bit function on the current LSBs of the operand shifters.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    res_bit   = 1'b0;
    carry_nxt = carry;
    unique case (op)
      OP_ADD: begin
        res_bit   = shift_a[0] ^ shift_b[0] ^ carry;
        carry_nxt = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) |
                    (shift_b[0] & carry);
      end
      // Subtract as A + ~B + 1: the +1 comes from the carry preset at start,
      // so a final carry of 1 means no borrow.
      OP_SUB: begin
        res_bit   = shift_a[0] ^ ~shift_b[0] ^ carry;
        carry_nxt = (shift_a[0] & ~shift_b[0]) | (shift_a[0] & carry) |
                    (~shift_b[0] & carry);
      end
      OP_AND:   res_bit = shift_a[0] & shift_b[0];
      OP_OR:    res_bit = shift_a[0] | shift_b[0];
      OP_XOR:   res_bit = shift_a[0] ^ shift_b[0];
      OP_PASSB: res_bit = shift_b[0];
      OP_INC: begin
        res_bit   = shift_a[0] ^ carry;
        carry_nxt = shift_a[0] & carry;
      end
      OP_NOTA:  res_bit = ~shift_a[0];
      default: begin
        res_bit   = 1'b0;
        carry_nxt = carry;
      end
    endcase
  end

  assign is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge values of the others regardless of statement order.
      state        <= IDLE;
      op           <= OP_ADD;
      shift_a      <= '0;
      shift_b      <= '0;
      bit_cnt      <= '0;
      carry        <= 1'b0;
      zero_acc     <= 1'b0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            shift_a  <= bus.operand_a;
            shift_b  <= bus.operand_b;
            op       <= op_e'(bus.opcode);
            bit_cnt  <= '0;
            zero_acc <= 1'b1;
            // SUB and INC need the initial +1 injected through the carry.
            carry    <= (bus.opcode == OP_SUB) || (bus.opcode == OP_INC);
          end
        end
        RUN: begin
          shift_a  <= shift_a >> 1;
          shift_b  <= shift_b >> 1;
          carry    <= carry_nxt;
          zero_acc <= zero_acc & ~res_bit;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state        <= DONE;
            carry_flag_q <= is_arith ? carry_nxt : 1'b0;
            // Fold in the last bit here; zero_acc itself only has it next cycle.
            zero_flag_q  <= zero_acc & ~res_bit;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stream and status outputs decode straight from state, so an asynchronous
  // reset silences them immediately.
  assign bus.acc_write_en = (state == RUN);
  assign bus.alu_result   = (state == RUN) ? res_bit : 1'b0;
  assign bus.done         = (state == DONE);
  assign bus.busy         = (state == RUN) || (state == DONE);
  assign bus.carry_flag   = carry_flag_q;
  assign bus.zero_flag    = zero_flag_q;

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Bit-serial ALU stage directly upstream of the accumulator.
- On a start request it latches two WIDTH-bit operands and an opcode, then streams the result LSB-first, one bit per clock.
- Each result bit is driven on alu_result with acc_write_en high, so the accumulator captures bit i on cycle i of the run.
- Produces a one-cycle done pulse plus carry and zero flags for the control unit.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request a new operation; sampled only in IDLE
- opcode  input  3  operation select, sampled with start
- operand_a  input  WIDTH  first operand (normally the accumulator contents), sampled with start
- operand_b  input  WIDTH  second operand, sampled with start
- alu_result  output  1  current result bit, LSB first
- acc_write_en  output  1  high while a valid result bit is on alu_result
- busy  output  1  high in RUN and DONE
- done  output  1  single-cycle pulse after the last bit
- carry_flag  output  1  carry/borrow-not of the last arithmetic operation
- zero_flag  output  1  high when the last result was all zeros

Behaviour:
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1.
  - That edge loads shift_a<=operand_a, shift_b<=operand_b, op<=opcode, bit_cnt<=0, zero_acc<=1.
  - It also loads carry<=1 for SUB and INC, and carry<=0 otherwise.
- RUN lasts exactly WIDTH cycles (bit_cnt 0..WIDTH-1).
  - Each edge in RUN shifts shift_a and shift_b right by one and updates carry per the op.
  - Each edge in RUN does zero_acc<=zero_acc & ~alu_result and increments bit_cnt.
- RUN -> DONE on the edge where bit_cnt==WIDTH-1. That same edge latches:
  - carry_flag<=final carry-out for ADD/SUB/INC, and 0 for logic ops;
  - zero_flag<=zero_acc & ~alu_result (the final bit included).
- DONE -> IDLE unconditionally after one cycle. start is ignored in RUN and DONE; it is not queued.
- Output decode (combinational from state):
  - acc_write_en=1 only in RUN.
  - done=1 only in DONE.
  - busy=1 in RUN or DONE.
  - alu_result=0 outside RUN.
- Per-bit function in RUN, with a=shift_a[0], b=shift_b[0], c=carry:
  - 000 ADD: a^b^c, carry<=maj(a,b,c)
  - 001 SUB: a^~b^c, carry<=maj(a,~b,c); final carry 1 = no borrow
  - 010 AND: a&b
  - 011 OR: a|b
  - 100 XOR: a^b
  - 101 PASSB: b
  - 110 INC: a^c, carry<=a&c (adds 1 to A)
  - 111 NOTA: ~a
- Latency: start sampled on edge E0. Bit i appears in the cycle after edge E0+i, for i=0..WIDTH-1. done is high in the cycle after edge E0+WIDTH.
- Exactly WIDTH acc_write_en cycles per operation, contiguous, never split.
- Flags: reset to 0; hold their value between operations; change only on the RUN->DONE edge.
- Reset asserted at any time, including mid-RUN:
  - state<=IDLE, all internal registers and flags <=0.
  - alu_result, acc_write_en, busy and done go low immediately, since they are state-decoded.
  - A partially streamed operation is abandoned; no done pulse is produced.
- start held high continuously gives one operation per WIDTH+2 cycles (IDLE, WIDTH RUN cycles, DONE).
- Operand inputs may change freely after the start edge; only the latched copies are used.

Test Plan:
- ADD a=0x7F b=0x01 -> alu_result bits LSB-first 0,0,0,0,0,0,0,1 (0x80); acc_write_en high 8 cycles; done pulse 1 cycle; carry_flag=0, zero_flag=0.
- ADD a=0xFF b=0x01 -> result 0x00, carry_flag=1, zero_flag=1. Then XOR a=0xA5 b=0x0F -> result 0xAA, carry_flag=0, zero_flag=0.
- SUB a=0x05 b=0x07 -> result 0xFE, carry_flag=0 (borrow). SUB a=0x07 b=0x05 -> 0x02, carry_flag=1.
- INC a=0xFF -> 0x00, carry 1, zero 1. NOTA a=0x0F -> 0xF0. PASSB b=0x3C -> 0x3C. AND 0xF0&0x3C -> 0x30. OR 0xF0|0x0C -> 0xFC.
- Pulse start during RUN and during DONE with different operands -> ignored, first result unchanged, exactly 8 write-enable cycles. start held high -> done every 10 cycles.
- Assert rst_n low after bit 3 of an ADD -> all outputs 0 immediately, no done pulse, flags 0. After release, a new ADD 0x01+0x01 yields 0x02 normally.
